// File: rtl/quiz_round_timer.sv
// quiz_round_timer: round countdown timer for a quiz buzzer system.
// A prescaler divides clk_in by DIV to produce round ticks; time_left counts
// the remaining ticks of the current round down to zero.
// Optional feature macro: QUIZ_WARN_EN adds a registered 'warn' output that
// is high while a round is running with 0 < time_left <= WARN_THRESH.
module quiz_round_timer #(
    parameter int DIV         = 10,
    parameter int CNT_W       = 7,
    parameter int WARN_THRESH = 5
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [CNT_W-1:0] round_len,
    output logic [CNT_W-1:0] time_left,
    output logic             tick,
    output logic             running,
    output logic             expired
`ifdef QUIZ_WARN_EN
    ,
    output logic             warn
`endif
);

    localparam int PS_W = $clog2(DIV);
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(DIV - 1);
    localparam logic [PS_W-1:0]  PS_ZERO = {PS_W{1'b0}};
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [CNT_W-1:0] TL_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TL_ONE  = CNT_W'(1);

    // Reject configurations outside the supported range at elaboration.
    if (DIV < 2 || DIV > 65535 || WARN_THRESH < 0) begin : g_param_check
        $error("quiz_round_timer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [PS_W-1:0]  presc_r;
    logic [PS_W-1:0]  presc_s;
    logic [CNT_W-1:0] time_left_r;
    logic [CNT_W-1:0] time_left_s;
    logic             tick_r;
    logic             tick_s;
    logic             expired_r;
    logic             expired_s;
    logic             running_r;
    logic             running_s;

    // Next-state logic: abort beats start, start beats pause.
    always_comb begin
        state_s     = state_r;
        presc_s     = presc_r;
        time_left_s = time_left_r;
        tick_s      = 1'b0;
        expired_s   = 1'b0;
        if (abort) begin
            state_s     = IDLE;
            presc_s     = PS_ZERO;
            time_left_s = TL_ZERO;
        end else if (start && (state_r == IDLE || state_r == DONE)) begin
            presc_s = PS_ZERO;
            if (round_len != TL_ZERO) begin
                state_s     = RUN;
                time_left_s = round_len;
            end else begin
                // Zero-length round finishes immediately.
                state_s     = DONE;
                time_left_s = TL_ZERO;
                expired_s   = 1'b1;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    presc_s     = PS_ZERO;
                    time_left_s = TL_ZERO;
                end
                RUN, PAUSE: begin
                    if (pause) begin
                        // Freeze prescaler and time_left while paused.
                        state_s = PAUSE;
                    end else if (presc_r >= PS_MAX) begin
                        presc_s = PS_ZERO;
                        tick_s  = 1'b1;
                        if (time_left_r <= TL_ONE) begin
                            // Last tick of the round; never go below zero.
                            state_s     = DONE;
                            time_left_s = TL_ZERO;
                            expired_s   = 1'b1;
                        end else begin
                            state_s     = RUN;
                            time_left_s = time_left_r - TL_ONE;
                        end
                    end else begin
                        state_s = RUN;
                        presc_s = presc_r + PS_ONE;
                    end
                end
                DONE: begin
                    presc_s     = PS_ZERO;
                    time_left_s = TL_ZERO;
                end
                default: begin
                    state_s     = IDLE;
                    presc_s     = PS_ZERO;
                    time_left_s = TL_ZERO;
                end
            endcase
        end
        running_s = (state_s == RUN) || (state_s == PAUSE);
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            presc_r     <= PS_ZERO;
            time_left_r <= TL_ZERO;
            tick_r      <= 1'b0;
            expired_r   <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            presc_r     <= presc_s;
            time_left_r <= time_left_s;
            tick_r      <= tick_s;
            expired_r   <= expired_s;
            running_r   <= running_s;
        end
    end

    assign time_left = time_left_r;
    assign tick      = tick_r;
    assign running   = running_r;
    assign expired   = expired_r;

`ifdef QUIZ_WARN_EN
    logic warn_r;
    logic warn_s;

    // Warning window: running with a small non-zero number of ticks left.
    always_comb begin
        if (running_s && time_left_s != TL_ZERO &&
            time_left_s <= CNT_W'(WARN_THRESH)) begin
            warn_s = 1'b1;
        end else begin
            warn_s = 1'b0;
        end
    end

    // Register the warning so it lines up with time_left.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            warn_r <= 1'b0;
        end else begin
            warn_r <= warn_s;
        end
    end

    assign warn = warn_r;
`endif

endmodule
